// File: rtl/iog_dly_step_sched_pkg.sv
// Shared types and constants for the IOG delay-line step sequencer.
// The state encoding and requester ids are common to the top level, the arbiter and the interface.
package iog_dly_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_PULSE = 3'd2,
        ST_GAP   = 3'd3,
        ST_LOAD  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam int LANE_BITS  = 9;
    localparam int LANE_IDX_W = 4;

    localparam logic SRC_TRN = 1'b0;
    localparam logic SRC_DBG = 1'b1;

endpackage

// File: rtl/iog_dly_step_sched_if.sv
// Request/grant bundle of one delay-line requester (training engine or APB debug path).
// The requester holds req and its fields until it sees the one-cycle ack.
interface iog_dly_step_sched_if
    import iog_dly_pkg::*;
#(
    parameter int CNT_W = 8
);
    logic                  req;
    logic [LANE_IDX_W-1:0] lane;
    logic [LANE_BITS-1:0]  bits;
    logic                  dir;
    logic                  load;
    logic [CNT_W-1:0]      steps;
    logic                  ack;

    modport master (output req, lane, bits, dir, load, steps, input ack);
    modport slave  (input req, lane, bits, dir, load, steps, output ack);

endinterface

// File: rtl/iog_dly_step_sched_arb.sv
// Two-way round-robin arbiter between the training engine and the debug path.
// The last-grant pointer starts at debug so that training wins the first contested arbitration.
module iog_dly_arb
    import iog_dly_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_trn_req,
    input  logic i_dbg_req,
    input  logic i_grant_en,
    output logic o_gnt_vld,
    output logic o_gnt_src,
    output logic o_trn_ack,
    output logic o_dbg_ack
);

    logic r_last_src;
    logic r_trn_ack;
    logic r_dbg_ack;
    logic w_gnt_vld;
    logic w_gnt_src;

    // Winner selection: when both requesters contend, the one not granted last wins.
    always_comb begin
        w_gnt_vld = i_grant_en & (i_trn_req | i_dbg_req);
        w_gnt_src = SRC_TRN;
        if (i_trn_req && i_dbg_req) begin
            if (r_last_src == SRC_DBG) begin
                w_gnt_src = SRC_TRN;
            end else begin
                w_gnt_src = SRC_DBG;
            end
        end else if (i_dbg_req) begin
            w_gnt_src = SRC_DBG;
        end else begin
            w_gnt_src = SRC_TRN;
        end
    end

    // Registered ack pulses and the last-grant pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_src <= SRC_DBG;
            r_trn_ack  <= 1'b0;
            r_dbg_ack  <= 1'b0;
        end else begin
            r_trn_ack <= w_gnt_vld && (w_gnt_src == SRC_TRN);
            r_dbg_ack <= w_gnt_vld && (w_gnt_src == SRC_DBG);
            if (w_gnt_vld) begin
                r_last_src <= w_gnt_src;
            end
        end
    end

    assign o_gnt_vld = w_gnt_vld;
    assign o_gnt_src = w_gnt_src;
    assign o_trn_ack = r_trn_ack;
    assign o_dbg_ack = r_dbg_ack;

endmodule

// File: rtl/iog_dly_step_sched.sv
// Sequences direction-setup / move-pulse / gap trains (or a single load pulse) on one IOG lane,
// arbitrating between training and debug requesters; all outputs are registered from the next state.
module iog_dly_step_sched
    import iog_dly_pkg::*;
#(
    parameter int IOG_DQS_LANES = 9,
    parameter int DIR_SETUP     = 1,
    parameter int STEP_GAP      = 3,
    parameter int CNT_W         = 8
)(
    input  logic                                SCLK,
    input  logic                                reset_n,
    iog_dly_step_sched_if.slave                 trn,
    iog_dly_step_sched_if.slave                 dbg,
    input  logic [IOG_DQS_LANES*LANE_BITS-1:0]  rx_out_of_range,
    output logic                                busy,
    output logic                                done,
    output logic                                done_src,
    output logic [CNT_W-1:0]                    done_steps,
    output logic                                done_oor,
    output logic                                done_err,
    output logic [IOG_DQS_LANES*LANE_BITS-1:0]  direction,
    output logic [IOG_DQS_LANES*LANE_BITS-1:0]  load,
    output logic [IOG_DQS_LANES*LANE_BITS-1:0]  move
);

    localparam int NB      = IOG_DQS_LANES * LANE_BITS;
    localparam int TMR_MAX = (DIR_SETUP > STEP_GAP) ? DIR_SETUP : STEP_GAP;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam logic [TMR_W-1:0]      SETUP_LAST = TMR_W'(DIR_SETUP - 1);
    localparam logic [TMR_W-1:0]      GAP_LAST   = TMR_W'(STEP_GAP - 1);
    localparam logic [LANE_IDX_W-1:0] LANE_LIMIT = LANE_IDX_W'(IOG_DQS_LANES);

    state_e                r_state;
    state_e                w_nxt;
    logic [LANE_IDX_W-1:0] r_lane;
    logic [LANE_BITS-1:0]  r_bits;
    logic                  r_dir;
    logic                  r_load;
    logic                  r_src;
    logic [CNT_W-1:0]      r_steps;
    logic [CNT_W-1:0]      r_cnt;
    logic [TMR_W-1:0]      r_tmr;

    logic                  r_busy;
    logic                  r_done;
    logic                  r_done_src;
    logic [CNT_W-1:0]      r_done_steps;
    logic                  r_done_oor;
    logic                  r_done_err;
    logic [NB-1:0]         r_direction;
    logic [NB-1:0]         r_load_o;
    logic [NB-1:0]         r_move;

    logic                  w_gnt_vld;
    logic                  w_gnt_src;
    logic                  w_trn_ack;
    logic                  w_dbg_ack;
    logic                  w_ack_any;
    logic                  w_grant_en;
    logic                  w_lane_err;
    logic                  w_oor_hit;
    logic [NB-1:0]         w_sel;
    logic [NB-1:0]         w_dir_nxt;
    logic [NB-1:0]         w_load_nxt;
    logic [NB-1:0]         w_move_nxt;

    // Places a lane mask at its lane position; out-of-range lanes select nothing.
    function automatic logic [NB-1:0] f_expand(input logic [LANE_IDX_W-1:0] lane,
                                               input logic [LANE_BITS-1:0]  mask);
        logic [NB-1:0] v;
        v = '0;
        for (int l = 0; l < IOG_DQS_LANES; l++) begin
            if (lane == LANE_IDX_W'(l)) begin
                v[l*LANE_BITS +: LANE_BITS] = mask;
            end
        end
        return v;
    endfunction

    // Arbitration is open in idle (outside the ack cycle) and in DONE, so a new ack can follow DONE directly.
    assign w_ack_any  = w_trn_ack | w_dbg_ack;
    assign w_grant_en = ((r_state == ST_IDLE) && !w_ack_any) || (r_state == ST_DONE);

    iog_dly_arb u_arb (
        .i_clk      (SCLK),
        .i_rst_n    (reset_n),
        .i_trn_req  (trn.req),
        .i_dbg_req  (dbg.req),
        .i_grant_en (w_grant_en),
        .o_gnt_vld  (w_gnt_vld),
        .o_gnt_src  (w_gnt_src),
        .o_trn_ack  (w_trn_ack),
        .o_dbg_ack  (w_dbg_ack)
    );

    assign trn.ack    = w_trn_ack;
    assign dbg.ack    = w_dbg_ack;
    assign w_sel      = f_expand(r_lane, r_bits);
    assign w_lane_err = (r_lane >= LANE_LIMIT);
    assign w_oor_hit  = |(rx_out_of_range & w_sel);

    // Request capture at grant, and the issued-step counter.
    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_lane  <= '0;
            r_bits  <= '0;
            r_dir   <= 1'b0;
            r_load  <= 1'b0;
            r_src   <= SRC_TRN;
            r_steps <= '0;
            r_cnt   <= '0;
        end else if (w_gnt_vld) begin
            r_src <= w_gnt_src;
            r_cnt <= '0;
            if (w_gnt_src == SRC_DBG) begin
                r_lane  <= dbg.lane;
                r_bits  <= dbg.bits;
                r_dir   <= dbg.dir;
                r_load  <= dbg.load;
                r_steps <= dbg.steps;
            end else begin
                r_lane  <= trn.lane;
                r_bits  <= trn.bits;
                r_dir   <= trn.dir;
                r_load  <= trn.load;
                r_steps <= trn.steps;
            end
        end else if (r_state == ST_PULSE) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // State register and the setup/gap dwell timer.
    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_tmr   <= '0;
        end else begin
            r_state <= w_nxt;
            if ((w_nxt == r_state) && ((r_state == ST_SETUP) || (r_state == ST_GAP))) begin
                r_tmr <= r_tmr + TMR_W'(1);
            end else begin
                r_tmr <= '0;
            end
        end
    end

    // Next-state logic; an out-of-range flag beats step completion on the last gap cycle.
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_ack_any) begin
                    if (w_lane_err) begin
                        w_nxt = ST_DONE;
                    end else if (r_load) begin
                        w_nxt = ST_LOAD;
                    end else if (r_steps == '0) begin
                        w_nxt = ST_DONE;
                    end else begin
                        w_nxt = ST_SETUP;
                    end
                end else begin
                    w_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (r_tmr == SETUP_LAST) begin
                    w_nxt = ST_PULSE;
                end else begin
                    w_nxt = ST_SETUP;
                end
            end
            ST_PULSE: w_nxt = ST_GAP;
            ST_GAP: begin
                if (r_tmr == GAP_LAST) begin
                    if (w_oor_hit) begin
                        w_nxt = ST_DONE;
                    end else if (r_cnt == r_steps) begin
                        w_nxt = ST_DONE;
                    end else begin
                        w_nxt = ST_PULSE;
                    end
                end else begin
                    w_nxt = ST_GAP;
                end
            end
            ST_LOAD: w_nxt = ST_DONE;
            ST_DONE: w_nxt = ST_IDLE;
            default: w_nxt = ST_IDLE;
        endcase
    end

    // Control vectors decoded from the next state so the registered outputs line up with the state.
    always_comb begin
        w_dir_nxt  = '0;
        w_load_nxt = '0;
        w_move_nxt = '0;
        if (((w_nxt == ST_SETUP) || (w_nxt == ST_PULSE) || (w_nxt == ST_GAP)) && r_dir) begin
            w_dir_nxt = w_sel;
        end else begin
            w_dir_nxt = '0;
        end
        if (w_nxt == ST_PULSE) begin
            w_move_nxt = w_sel;
        end else begin
            w_move_nxt = '0;
        end
        if (w_nxt == ST_LOAD) begin
            w_load_nxt = w_sel;
        end else begin
            w_load_nxt = '0;
        end
    end

    // Output registers; the status fields only change on entry to DONE.
    always_ff @(posedge SCLK or negedge reset_n) begin
        if (!reset_n) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_done_src   <= 1'b0;
            r_done_steps <= '0;
            r_done_oor   <= 1'b0;
            r_done_err   <= 1'b0;
            r_direction  <= '0;
            r_load_o     <= '0;
            r_move       <= '0;
        end else begin
            r_busy      <= (w_nxt != ST_IDLE);
            r_done      <= (w_nxt == ST_DONE);
            r_direction <= w_dir_nxt;
            r_load_o    <= w_load_nxt;
            r_move      <= w_move_nxt;
            if (w_nxt == ST_DONE) begin
                r_done_src   <= r_src;
                r_done_steps <= r_cnt;
                r_done_oor   <= (r_state == ST_GAP) && w_oor_hit;
                r_done_err   <= w_lane_err;
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign done_src   = r_done_src;
    assign done_steps = r_done_steps;
    assign done_oor   = r_done_oor;
    assign done_err   = r_done_err;
    assign direction  = r_direction;
    assign load       = r_load_o;
    assign move       = r_move;

endmodule

// File: tb/tb_iog_dly_step_sched.sv
// Directed bench for iog_dly_step_sched: a per-cycle timeline model of each request is checked at the falling edge.
module tb_iog_dly_step_sched;

    logic        SCLK = 1'b0;
    logic        reset_n = 1'b0;
    logic [80:0] rx_out_of_range = '0;
    logic        busy, done, done_src, done_oor, done_err;
    logic [7:0]  done_steps;
    logic [80:0] direction, ld_o, move;

    int checks = 0;
    int failures = 0;

    iog_dly_step_sched_if #(.CNT_W(8)) trn_if ();
    iog_dly_step_sched_if #(.CNT_W(8)) dbg_if ();

    iog_dly_step_sched #(
        .IOG_DQS_LANES(9), .DIR_SETUP(1), .STEP_GAP(3), .CNT_W(8)
    ) dut (
        .SCLK            (SCLK),
        .reset_n         (reset_n),
        .trn             (trn_if),
        .dbg             (dbg_if),
        .rx_out_of_range (rx_out_of_range),
        .busy            (busy),
        .done            (done),
        .done_src        (done_src),
        .done_steps      (done_steps),
        .done_oor        (done_oor),
        .done_err        (done_err),
        .direction       (direction),
        .load            (ld_o),
        .move            (move)
    );

    always #5 SCLK = ~SCLK;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input bit is_dbg, input logic [3:0] lane, input logic [8:0] bits,
                           input bit dir, input bit ld, input logic [7:0] steps);
        if (is_dbg) begin
            dbg_if.lane = lane; dbg_if.bits = bits; dbg_if.dir = dir;
            dbg_if.load = ld; dbg_if.steps = steps; dbg_if.req = 1'b1;
        end else begin
            trn_if.lane = lane; trn_if.bits = bits; trn_if.dir = dir;
            trn_if.load = ld; trn_if.steps = steps; trn_if.req = 1'b1;
        end
    endtask

    // Issues one request and checks every cycle from ack to one cycle past done against a timeline model.
    task automatic do_req(input string tag, input bit is_dbg, input logic [3:0] lane,
                          input logic [8:0] bits, input bit dir, input bit ld,
                          input logic [7:0] steps, input int oor_move);
        int got, done_at, exp_steps;
        bit normal, exp_oor, exp_err;
        logic [80:0] sel, e_dir, e_move, e_load;
        got = 0;
        set_req(is_dbg, lane, bits, dir, ld, steps);
        for (int i = 0; i < 20 && got == 0; i++) begin
            @(negedge SCLK);
            if ((is_dbg ? dbg_if.ack : trn_if.ack) === 1'b1) got = 1;
        end
        chk({tag, ":ack"}, 128'(got), 128'(1));
        trn_if.req = 1'b0;
        dbg_if.req = 1'b0;
        if (got == 0) return;

        sel = '0;
        if (lane < 4'd9) sel = 81'(bits) << (int'(lane) * 9);
        normal = 1'b0; exp_oor = 1'b0; exp_err = 1'b0; exp_steps = 0;
        if (lane >= 4'd9) begin
            done_at = 1; exp_err = 1'b1;
        end else if (ld) begin
            done_at = 2;
        end else if (steps == 8'd0) begin
            done_at = 1;
        end else if (oor_move > 0 && oor_move <= int'(steps)) begin
            normal = 1'b1; done_at = 2 + 4 * oor_move; exp_steps = oor_move; exp_oor = 1'b1;
        end else begin
            normal = 1'b1; done_at = 2 + 4 * int'(steps); exp_steps = int'(steps);
        end

        for (int k = 1; k <= done_at + 1; k++) begin
            @(negedge SCLK);
            e_move = (normal && k >= 2 && k < done_at && ((k - 2) % 4) == 0) ? sel : '0;
            e_dir  = (normal && dir && k < done_at) ? sel : '0;
            e_load = (ld && lane < 4'd9 && k == 1) ? sel : '0;
            chk($sformatf("%s:move@%0d", tag, k), 128'(move), 128'(e_move));
            chk($sformatf("%s:dir@%0d", tag, k), 128'(direction), 128'(e_dir));
            chk($sformatf("%s:load@%0d", tag, k), 128'(ld_o), 128'(e_load));
            chk($sformatf("%s:busy@%0d", tag, k), 128'(busy), 128'(k <= done_at));
            chk($sformatf("%s:done@%0d", tag, k), 128'(done), 128'(k == done_at));
            if (k == done_at) begin
                chk({tag, ":done_src"}, 128'(done_src), 128'(is_dbg));
                chk({tag, ":done_steps"}, 128'(done_steps), 128'(exp_steps));
                chk({tag, ":done_oor"}, 128'(done_oor), 128'(exp_oor));
                chk({tag, ":done_err"}, 128'(done_err), 128'(exp_err));
            end
            if (oor_move > 0 && k == 2 + 4 * (oor_move - 1)) begin
                rx_out_of_range = 81'(1) << (int'(lane) * 9);
            end
        end
        rx_out_of_range = '0;
    endtask

    initial begin
        int n_ack;
        int ack_t[4];
        bit ack_s[4];
        bit got;
        logic [80:0] sel3;

        trn_if.req = 1'b0; trn_if.lane = '0; trn_if.bits = '0; trn_if.dir = 1'b0;
        trn_if.load = 1'b0; trn_if.steps = '0;
        dbg_if.req = 1'b0; dbg_if.lane = '0; dbg_if.bits = '0; dbg_if.dir = 1'b0;
        dbg_if.load = 1'b0; dbg_if.steps = '0;

        // Reset state
        repeat (3) @(negedge SCLK);
        chk("rst:busy", 128'(busy), 128'(0));
        chk("rst:done", 128'(done), 128'(0));
        chk("rst:ctrl", 128'(direction | ld_o | move), 128'(0));
        chk("rst:acks", 128'({trn_if.ack, dbg_if.ack}), 128'(0));
        chk("rst:status", 128'({done_src, done_steps, done_oor, done_err}), 128'(0));
        reset_n = 1'b1;
        @(negedge SCLK);

        // Round-robin with both requesters held: trn, dbg, trn, dbg every 7 cycles
        set_req(1'b0, 4'd1, 9'h001, 1'b1, 1'b0, 8'd1);
        set_req(1'b1, 4'd4, 9'h100, 1'b0, 1'b0, 8'd1);
        n_ack = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge SCLK);
            chk("rr:ack_vs_busy", 128'((trn_if.ack | dbg_if.ack) & busy), 128'(0));
            if ((trn_if.ack === 1'b1 || dbg_if.ack === 1'b1) && n_ack < 4) begin
                ack_t[n_ack] = i;
                ack_s[n_ack] = dbg_if.ack;
                n_ack++;
                if (n_ack == 4) begin
                    trn_if.req = 1'b0;
                    dbg_if.req = 1'b0;
                end
            end
        end
        chk("rr:ack_count", 128'(n_ack), 128'(4));
        if (n_ack == 4) begin
            chk("rr:order", 128'({ack_s[0], ack_s[1], ack_s[2], ack_s[3]}), 128'(4'b0101));
            chk("rr:t0", 128'(ack_t[0]), 128'(0));
            chk("rr:t1", 128'(ack_t[1]), 128'(7));
            chk("rr:t2", 128'(ack_t[2]), 128'(14));
            chk("rr:t3", 128'(ack_t[3]), 128'(21));
        end
        chk("rr:idle_after", 128'(busy), 128'(0));

        // Main function patterns and boundaries
        do_req("trn_l2_s3", 1'b0, 4'd2, 9'h1FF, 1'b1, 1'b0, 8'd3, 0);
        do_req("dbg_load", 1'b1, 4'd0, 9'h004, 1'b1, 1'b1, 8'd7, 0);
        do_req("dbg_l8_s2", 1'b1, 4'd8, 9'h0A5, 1'b0, 1'b0, 8'd2, 0);
        do_req("trn_oor", 1'b0, 4'd5, 9'h1FF, 1'b1, 1'b0, 8'd10, 4);
        do_req("trn_oor_last", 1'b0, 4'd7, 9'h011, 1'b1, 1'b0, 8'd2, 2);
        do_req("trn_lane9", 1'b0, 4'd9, 9'h1FF, 1'b1, 1'b0, 8'd4, 0);
        do_req("trn_s0", 1'b0, 4'd1, 9'h0F0, 1'b1, 1'b0, 8'd0, 0);
        do_req("dbg_s255", 1'b1, 4'd6, 9'h003, 1'b1, 1'b0, 8'd255, 0);

        // Reset during the GAP of a 5-step sequence
        sel3 = 81'(9'h1FF) << 27;
        set_req(1'b0, 4'd3, 9'h1FF, 1'b1, 1'b0, 8'd5);
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge SCLK);
            if (trn_if.ack === 1'b1) got = 1'b1;
        end
        chk("rstmid:ack", 128'(got), 128'(1));
        trn_if.req = 1'b0;
        repeat (4) @(negedge SCLK);
        chk("rstmid:busy_pre", 128'(busy), 128'(1));
        chk("rstmid:dir_pre", 128'(direction), 128'(sel3));
        #2 reset_n = 1'b0;
        #1;
        chk("rstmid:dir_async", 128'(direction), 128'(0));
        chk("rstmid:busy_async", 128'(busy), 128'(0));
        chk("rstmid:move_async", 128'(move | ld_o), 128'(0));
        for (int i = 0; i < 3; i++) begin
            @(negedge SCLK);
            chk("rstmid:no_done", 128'(done), 128'(0));
        end
        reset_n = 1'b1;
        set_req(1'b0, 4'd0, 9'h001, 1'b0, 1'b0, 8'd1);
        set_req(1'b1, 4'd0, 9'h002, 1'b0, 1'b0, 8'd1);
        @(negedge SCLK);
        chk("rstmid:trn_first", 128'({trn_if.ack, dbg_if.ack}), 128'(2'b10));
        trn_if.req = 1'b0;
        dbg_if.req = 1'b0;
        repeat (8) @(negedge SCLK);
        chk("rstmid:idle_end", 128'(busy), 128'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/iog_dly_step_sched.md
Name: iog_dly_step_sched

Overview:
Sequences IOG delay-line adjustments (direction/load/move) for one lane at a time. Arbitrates between the training engine and the APB debug path. Each granted request becomes a timed direction-setup/move-pulse/gap sequence, or a single load pulse. The sequence aborts early on rx_out_of_range. The block sits between the requesters and the per-lane IOG delay-line controls.

Parameters:
IOG_DQS_LANES, 9, number of DQS lanes; each lane has 9 IOG delay lines.
DIR_SETUP, 1, cycles direction is held before the first move (min 1).
STEP_GAP, 3, idle cycles after every move pulse (min 1).
CNT_W, 8, width of step count fields.

Ports:
SCLK  in  1  clock.
reset_n  in  1  async active-low reset.
trn_req  in  1  training request; held until trn_ack.
trn_lane  in  4  target lane.
trn_bits  in  9  delay-line mask within lane.
trn_dir  in  1  step direction.
trn_load  in  1  1 = load operation, steps ignored.
trn_steps  in  CNT_W  number of move pulses.
trn_ack  out  1  one-cycle grant pulse; fields captured this cycle.
dbg_req, dbg_lane, dbg_bits, dbg_dir, dbg_load, dbg_steps  in  1/4/9/1/1/CNT_W  debug requester, same meaning as trn_*.
dbg_ack  out  1  debug grant pulse.
rx_out_of_range  in  IOG_DQS_LANES*9  per-delay-line range flags.
busy  out  1  high from the cycle after ack until the DONE cycle inclusive.
done  out  1  one-cycle completion pulse.
done_src  out  1  0 = trn, 1 = dbg; valid with done.
done_steps  out  CNT_W  move pulses actually issued.
done_oor  out  1  sequence aborted on out-of-range.
done_err  out  1  lane index >= IOG_DQS_LANES; no pulses issued.
direction, load, move  out  IOG_DQS_LANES*9 each  delay-line controls; only bits lane*9+mask are ever nonzero.

Behaviour:
- Reset (async): state IDLE; all outputs 0; last-grant pointer = dbg, so trn wins first.
- Reset asserted mid-sequence: outputs drop to 0 immediately. No done is issued.
- All outputs are registered. "Asserted in state X" means high in exactly the cycles the FSM is in X.
- States: IDLE, SETUP, PULSE, GAP, LOAD, DONE.
- IDLE: if any request is pending, grant one.
  - If both are pending, grant the one not granted last (round-robin).
  - Ack pulses in the grant cycle; lane, bits, dir, load and steps are latched.
  - A requester still high in the cycle after its ack is treated as a new request.
  - No grant is made while busy.
- Transitions after grant, in priority order:
  - lane >= IOG_DQS_LANES -> DONE with done_err=1.
  - load=1 -> LOAD (1 cycle) -> DONE.
  - steps=0 -> DONE with done_steps=0.
  - otherwise -> SETUP.
- SETUP: lasts DIR_SETUP cycles, then PULSE.
- direction[sel] = latched dir from SETUP through the final GAP; it is 0 in DONE and IDLE.
- PULSE: move[sel]=1 for 1 cycle; the issued-step counter increments; then GAP.
- GAP: lasts STEP_GAP cycles. On the last GAP cycle, evaluate OR(rx_out_of_range[sel]):
  - 1 -> DONE with done_oor=1. This also applies on the final step.
  - else, if count == steps -> DONE.
  - else -> PULSE.
- LOAD: load[sel]=1 for 1 cycle; direction stays 0.
- DONE: done=1 with the status fields for 1 cycle, then IDLE.
  - Status fields hold their value until the next done.
  - A new grant is possible in the cycle after DONE.
- Timing for a normal request with DIR_SETUP=1, STEP_GAP=3:
  - ack at T; SETUP T+1; moves at T+2, T+6, …, T+2+4(N-1); done at T+2+4N.
- Counter width is CNT_W; steps = 2^CNT_W-1 must complete without wrap.

Decomposition:
- Package iog_dly_pkg holds:
  - state enum (IDLE, SETUP, PULSE, GAP, LOAD, DONE);
  - LANE_BITS=9, LANE_IDX_W=4;
  - SRC_TRN/SRC_DBG constants.
- Sub-module iog_dly_arb: 2-way round-robin arbiter with last-grant register and ack generation.
- Bit-select expansion (lane, mask) -> 81-bit vector stays in the top module.

Test Plan:
- trn lane 2, bits 9'h1FF, dir 1, steps 3 -> ack at T; move[26:18]=1FF at T+2, T+6, T+10; direction[26:18] high T+1..T+13; done at T+14 with steps=3, oor=0, err=0.
- dbg load, lane 0, bits 9'h004 -> load[2]=1 for exactly one cycle; direction and move stay 0; done with steps=0, src=1.
- trn_req and dbg_req both held, steps=1 each -> grant order after reset is trn, dbg, trn, dbg; no overlap in busy.
- trn lane 5, steps 10; rx_out_of_range[45] raised after the 4th move -> abort at the end of that GAP; done_oor=1, done_steps=4; no 5th move.
- trn lane 9 -> ack; done next cycle with done_err=1; all 81 control bits stay 0. Separately, steps=0 -> done with steps=0 and no move.
- reset_n low during the GAP of a 5-step sequence -> outputs 0 asynchronously; no done; after release, trn wins the first arbitration.
